// File: rtl/frac_clk_div_if.sv
// -----------------------------------------------------------------------------
// frac_clk_div_if
//   Bundles the frequency control word and the generated clock of
//   frac_clk_div.
//   master : drives div, observes clkout (the upstream controller / bench)
//   slave  : consumes div, produces clkout (the divider itself)
// Signals
//   div     W  frequency control word, unsigned, may change at any time
//   clkout  1  generated clock
// -----------------------------------------------------------------------------
interface frac_clk_div_if #(
  parameter int W = 32
);
  logic [W-1:0] div;
  logic         clkout;

  modport master (output div, input clkout);
  modport slave  (input div, output clkout);
endinterface

// File: rtl/frac_clk_div.sv
// -----------------------------------------------------------------------------
// frac_clk_div
//   Phase-accumulator fractional clock generator. Every clkin edge adds the
//   registered control word to a W-bit accumulator; the accumulator MSB is
//   the output clock, so f_out = f_clkin * div / 2**W. Control words above
//   2**(W-1) alias to 2**W - div.
// Ports
//   clkin    in  1  reference clock, rising edge
//   reset_n  in  1  asynchronous, active-low reset
//   bus      slave modport of frac_clk_div_if (div in, clkout out)
// -----------------------------------------------------------------------------
module frac_clk_div #(
  parameter int W = 32
) (
  input  logic          clkin,
  input  logic          reset_n,
  frac_clk_div_if.slave bus
);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    div_d = bus.div;
    // Modulo-2**W add: the carry out is the phase wrap and is dropped.
    acc_d = acc_q + div_q;
  end

  // Stage boundary: div is registered first, so a new word reaches acc one
  // edge after it is captured. acc is never cleared on a div change, which
  // keeps the output phase continuous.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      acc_q <= '0;
    end else begin
      div_q <= div_d;
      acc_q <= acc_d;
    end
  end

  // Straight from the flop: glitch-free, no combinational path from div.
  assign bus.clkout = acc_q[W-1];

endmodule

// File: tb/tb_frac_clk_div.sv
// -----------------------------------------------------------------------------
// tb_frac_clk_div
//   Self-checking bench for frac_clk_div (W = 32). Expected clkout values are
//   queued before each clkin edge and popped/compared 1 ns after it.
// -----------------------------------------------------------------------------
module tb_frac_clk_div;

  localparam int W = 32;

  logic clkin = 1'b0;
  logic reset_n = 1'b1;

  always #5 clkin = ~clkin;

  frac_clk_div_if #(.W(W)) bus ();

  frac_clk_div #(.W(W)) dut (
    .clkin   (clkin),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hold reset for two edges, then release on a falling edge with the given
  // control word already applied, so the next rising edge is "edge 1".
  task automatic start_from_reset(input logic [W-1:0] d);
    @(negedge clkin);
    reset_n = 1'b0;
    bus.div = d;
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    logic e;
    bus.div = 32'h4000_0000;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.clkout !== 1'b0 || dut.acc_q !== '0 || dut.div_q !== '0) begin
      errors++;
      $display("FAIL reset_async: clkout=%b acc=%h div_q=%h, required 0/0/0",
               bus.clkout, dut.acc_q, dut.div_q);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b0);
      @(posedge clkin); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.clkout !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d]: clkout=%b required %b", k, bus.clkout, e);
      end
    end
  endtask

  // div = 2**30: 0,0,1,1,0,0,... from edge 1, then an asynchronous reset
  // dropped while clkout is high, then the same sequence after release.
  task automatic test_quarter_and_async_reset;
    logic e;
    start_from_reset(32'h4000_0000);
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(1'(((k - 1) / 2) % 2));
      @(posedge clkin); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.clkout !== e) begin
        errors++;
        $display("FAIL quarter_edge%0d: clkout=%b required %b", k, bus.clkout, e);
      end
    end
    // After edge 15 clkout is 1; drop reset between edges.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.clkout !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: clkout=%b required 0", bus.clkout);
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(1'b0);
      @(posedge clkin); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.clkout !== e) begin
        errors++;
        $display("FAIL async_held[%0d]: clkout=%b required %b", k, bus.clkout, e);
      end
    end
    @(negedge clkin);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(1'(((k - 1) / 2) % 2));
      @(posedge clkin); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.clkout !== e) begin
        errors++;
        $display("FAIL restart_edge%0d: clkout=%b required %b", k, bus.clkout, e);
      end
    end
  endtask

  // div = 2**31: 0 on edge 1, then 1,0,1,0,... from edge 2.
  task automatic test_half;
    logic e;
    start_from_reset(32'h8000_0000);
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back((k >= 2 && (k % 2) == 0) ? 1'b1 : 1'b0);
      @(posedge clkin); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.clkout !== e) begin
        errors++;
        $display("FAIL half_edge%0d: clkout=%b required %b", k, bus.clkout, e);
      end
    end
  endtask

  // div = 0: accumulator frozen at 0, clkout stays 0.
  task automatic test_zero;
    logic e;
    start_from_reset('0);
    for (int k = 1; k <= 1000; k++) begin
      exp_q.push_back(1'b0);
      @(posedge clkin); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.clkout !== e) begin
        errors++;
        $display("FAIL zero_edge%0d: clkout=%b required %b", k, bus.clkout, e);
      end
    end
    checks++;
    if (dut.acc_q !== '0) begin
      errors++;
      $display("FAIL zero_acc: acc=%h required 0", dut.acc_q);
    end
  endtask

  // 2**30 -> 2**29 -> 3*2**30 mid-run. A reference accumulator predicts acc
  // and clkout, which proves acc carries on from its old value; rising-edge
  // spacing gives the period after each switch.
  task automatic test_div_change;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_divq;
    logic [W-1:0] words[3];
    int           lens[3];
    int           periods[3];
    int           edge_no;
    int           last_rise;
    int           prev_rise;
    logic         prev_out;
    logic         e;
    words   = '{32'h4000_0000, 32'h2000_0000, 32'hC000_0000};
    lens    = '{10, 30, 20};
    periods = '{4, 8, 4};
    start_from_reset(words[0]);
    m_acc = '0; m_divq = '0; edge_no = 0;
    last_rise = -1; prev_rise = -1; prev_out = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        @(negedge clkin);
        bus.div = words[p];
      end
      for (int k = 0; k < lens[p]; k++) begin
        m_acc  = m_acc + m_divq;
        m_divq = words[p];
        exp_q.push_back(m_acc[W-1]);
        @(posedge clkin); #1;
        edge_no++;
        e = exp_q.pop_front();
        checks++;
        if (bus.clkout !== e || dut.acc_q !== m_acc) begin
          errors++;
          $display("FAIL change_edge%0d: clkout=%b acc=%h required %b/%h",
                   edge_no, bus.clkout, dut.acc_q, e, m_acc);
        end
        if (bus.clkout === 1'b1 && prev_out === 1'b0) begin
          prev_rise = last_rise;
          last_rise = edge_no;
        end
        prev_out = bus.clkout;
      end
      checks++;
      if (last_rise - prev_rise !== periods[p]) begin
        errors++;
        $display("FAIL change_period%0d: period=%0d required %0d",
                 p, last_rise - prev_rise, periods[p]);
      end
    end
  endtask

  // div = 922441723 over N edges: rising-edge count N*div/2**32 +-1, and every
  // complete high/low run lasts 2 or 3 clkin cycles.
  task automatic test_frequency;
    localparam int N = 40000;
    localparam logic [W-1:0] D = 32'd922441723;
    longint expected;
    int     rises;
    int     run_len;
    int     runs_seen;
    int     bad_runs;
    logic   prev_out;
    start_from_reset(D);
    expected  = (longint'(N) * longint'(D)) >> 32;
    rises = 0; run_len = 0; runs_seen = 0; bad_runs = 0; prev_out = 1'b0;
    for (int k = 1; k <= N; k++) begin
      @(posedge clkin); #1;
      if (bus.clkout !== prev_out) begin
        if (bus.clkout === 1'b1) rises++;
        // The first run starts at reset release and is not a full run.
        if (runs_seen > 0 && (run_len < 2 || run_len > 3)) begin
          bad_runs++;
          if (bad_runs <= 5)
            $display("FAIL freq_run at edge %0d: length=%0d required 2..3", k, run_len);
        end
        runs_seen++;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_out = bus.clkout;
    end
    checks++;
    if (longint'(rises) < expected - 1 || longint'(rises) > expected + 1) begin
      errors++;
      $display("FAIL freq_count: rises=%0d required %0d +-1", rises, expected);
    end
    checks++;
    if (bad_runs !== 0) begin
      errors++;
      $display("FAIL freq_duty: bad runs=%0d required 0", bad_runs);
    end
  endtask

  initial begin
    bus.div = '0;
    test_reset();
    test_quarter_and_async_reset();
    test_half();
    test_zero();
    test_div_change();
    test_frequency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
